// File: rtl/dip_switch_debouncer.sv
// dip_switch_debouncer
//   Conditions a bank of raw DIP switch lines for the LED/status logic:
//   two-flop synchronisation, per-bit debouncing, one-cycle rise/fall pulses,
//   and a valid/ready change-event channel. Changes that arrive while an
//   event is pending are accumulated and issued as the next event.
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sw_raw      raw switch pins (asynchronous to clk)
//   sw_stable   debounced switch levels
//   sw_rise     one-cycle pulse per bit on debounced 0->1
//   sw_fall     one-cycle pulse per bit on debounced 1->0
//   evt_valid   change event pending
//   evt_ready   consumer accepts the event when evt_valid & evt_ready
//   evt_mask    bits that changed since the previous event was loaded
//   evt_state   sw_stable value when the event was loaded
//   evt_overrun a bit changed again while already pending in the accumulator
module dip_switch_debouncer #(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [N_SW-1:0] evt_mask,
  output logic [N_SW-1:0] evt_state,
  output logic            evt_overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state;
  logic [N_SW-1:0] sync_p0;
  logic [N_SW-1:0] sync_p1;
  logic [CNT_W-1:0] cnt_p2 [N_SW];
  logic [CNT_W-1:0] cnt_nxt [N_SW];
  logic [N_SW-1:0] stable_nxt;
  logic [N_SW-1:0] flip;
  logic [N_SW-1:0] acc;
  logic [N_SW-1:0] nxt;
  logic            ovr_acc;
  logic            repeat_flip;

  // Stage p2: per-bit debounce counters decide the next stable level
  always_comb begin
    stable_nxt = sw_stable;
    for (int i = 0; i < N_SW; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != sw_stable[i]) begin
        if (cnt_p2[i] == CNT_MAX)
          stable_nxt[i] = ~sw_stable[i];
        else
          cnt_nxt[i] = cnt_p2[i] + 1'b1;
      end
    end
  end

  // The event logic acts on this cycle's flips so an event is loaded on the
  // same edge that sw_stable and the edge pulses update.
  assign flip        = stable_nxt ^ sw_stable;
  assign nxt         = acc | flip;
  assign repeat_flip = |(acc & flip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      for (int i = 0; i < N_SW; i++) cnt_p2[i] <= '0;
      sw_stable   <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      state       <= IDLE;
      evt_valid   <= 1'b0;
      evt_mask    <= '0;
      evt_state   <= '0;
      evt_overrun <= 1'b0;
      acc         <= '0;
      ovr_acc     <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
      // Stage p2: debounced level and edge pulses
      for (int i = 0; i < N_SW; i++) cnt_p2[i] <= cnt_nxt[i];
      sw_stable <= stable_nxt;
      sw_rise   <= flip & stable_nxt;
      sw_fall   <= flip & ~stable_nxt;
      // Event channel
      case (state)
        IDLE: begin
          acc     <= '0;
          ovr_acc <= 1'b0;
          if (|flip) begin
            evt_valid   <= 1'b1;
            evt_mask    <= flip;
            evt_state   <= stable_nxt;
            evt_overrun <= 1'b0;
            state       <= PEND;
          end else begin
            evt_valid <= 1'b0;
          end
        end
        PEND: begin
          if (evt_ready) begin
            acc     <= '0;
            ovr_acc <= 1'b0;
            if (|nxt) begin
              // Back-to-back: everything gathered while pending becomes the next event.
              evt_mask    <= nxt;
              evt_state   <= stable_nxt;
              evt_overrun <= ovr_acc | repeat_flip;
            end else begin
              evt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            acc     <= nxt;
            ovr_acc <= ovr_acc | repeat_flip;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dip_switch_debouncer.sv
// Testbench for dip_switch_debouncer (DEBOUNCE_CYCLES = 4).
// A behavioural model tracks the expected outputs every cycle; each scenario
// task also checks the specific values that scenario is about.
module tb_dip_switch_debouncer;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_stable, sw_rise, sw_fall, evt_mask, evt_state;
  logic         evt_valid, evt_ready, evt_overrun;

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  dip_switch_debouncer #(.N_SW(N), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask),
    .evt_state(evt_state), .evt_overrun(evt_overrun)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [N-1:0] s1, s2, stable, rise, fall;
    logic         valid;
    logic [N-1:0] mask, state;
    logic         ovr;
    logic [N-1:0] acc;
    logic         ovacc;
  } model_t;

  model_t       m;
  logic [N-1:0] hist [$];  // previous D-1 synchronised samples

  // A level becomes stable once the synchronised input has shown the
  // opposite value for D consecutive clock edges.
  function automatic model_t model_next(model_t c, logic [N-1:0] raw, logic rdy,
                                        logic [N-1:0] win [$]);
    model_t n;
    logic [N-1:0] allo, allz, ns, fl, nx;
    logic rep;
    n = c;
    n.s1 = raw;
    n.s2 = c.s1;
    if (win.size() < D - 1) begin
      allo = '0;
      allz = '0;
    end else begin
      allo = c.s2;
      allz = ~c.s2;
      foreach (win[i]) begin
        allo &= win[i];
        allz &= ~win[i];
      end
    end
    ns = allo | (c.stable & ~allz);
    fl = ns ^ c.stable;
    n.stable = ns;
    n.rise = fl & ns;
    n.fall = fl & ~ns;
    nx = c.acc | fl;
    rep = (c.acc & fl) != 0;
    if (!c.valid) begin
      n.acc = '0;
      n.ovacc = 1'b0;
      if (fl != 0) begin
        n.valid = 1'b1; n.mask = fl; n.state = ns; n.ovr = 1'b0;
      end
    end else if (rdy) begin
      n.acc = '0;
      n.ovacc = 1'b0;
      if (nx != 0) begin
        n.mask = nx; n.state = ns; n.ovr = c.ovacc | rep;
      end else begin
        n.valid = 1'b0;
      end
    end else begin
      n.acc = nx;
      n.ovacc = c.ovacc | rep;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      hist.delete();
    end else begin
      m <= model_next(m, sw_raw, evt_ready, hist);
      hist.push_back(m.s2);
      if (hist.size() > D - 1) void'(hist.pop_front());
    end
  end

  logic [5*N+1:0] dut_vec, mdl_vec;
  assign dut_vec = {sw_stable, sw_rise, sw_fall, evt_valid, evt_mask, evt_state, evt_overrun};
  assign mdl_vec = {m.stable, m.rise, m.fall, m.valid, m.mask, m.state, m.ovr};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; sw_raw = '0; evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk++;
    if (dut_vec !== '0) begin
      err++; $display("FAIL reset_state: got %h required 0", dut_vec);
    end
    rst_n = 1'b1;
    sw_raw = 8'h01;
  endtask

  task automatic test_rise();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk++;
      if (sw_stable !== 8'h00 || sw_rise !== 8'h00 || evt_valid !== 1'b0) begin
        err++; $display("FAIL rise_early edge %0d: stable %h rise %h valid %b required 00 00 0",
                        k, sw_stable, sw_rise, evt_valid);
      end
    end
    @(negedge clk);
    chk++;
    if ({sw_stable, sw_rise, evt_valid, evt_mask, evt_state} !== {8'h01, 8'h01, 1'b1, 8'h01, 8'h01}) begin
      err++; $display("FAIL rise_edge6: stable %h rise %h valid %b mask %h state %h required 01 01 1 01 01",
                      sw_stable, sw_rise, evt_valid, evt_mask, evt_state);
    end
    @(negedge clk);
    chk++;
    if (sw_rise !== 8'h00 || evt_valid !== 1'b1) begin
      err++; $display("FAIL rise_pulse_width: rise %h valid %b required 00 1", sw_rise, evt_valid);
    end
  endtask

  task automatic test_glitch();
    sw_raw = 8'h09;
    repeat (3) @(negedge clk);
    sw_raw = 8'h01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk++;
      if (sw_stable !== 8'h01 || sw_rise !== 8'h00 || evt_valid !== 1'b1 || evt_mask !== 8'h01) begin
        err++; $display("FAIL glitch: stable %h rise %h valid %b mask %h required 01 00 1 01",
                        sw_stable, sw_rise, evt_valid, evt_mask);
      end
      chk++;
      if (dut_vec !== mdl_vec) begin
        err++; $display("FAIL glitch_model: got %h required %h", dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_hold_queue();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    sw_raw = 8'h00;
    repeat (8) @(negedge clk);
    chk++;
    if ({evt_valid, evt_mask, evt_state} !== {1'b1, 8'h01, 8'h00}) begin
      err++; $display("FAIL hold_first: valid %b mask %h state %h required 1 01 00", evt_valid, evt_mask, evt_state);
    end
    sw_raw = 8'h02;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk++;
      if ({evt_valid, evt_mask, evt_state, evt_overrun} !== {1'b1, 8'h01, 8'h00, 1'b0}) begin
        err++; $display("FAIL hold_held: valid %b mask %h state %h ovr %b required 1 01 00 0",
                        evt_valid, evt_mask, evt_state, evt_overrun);
      end
    end
    evt_ready = 1'b1;
    @(negedge clk);
    chk++;
    if ({evt_valid, evt_mask, evt_state, evt_overrun} !== {1'b1, 8'h02, 8'h02, 1'b0}) begin
      err++; $display("FAIL hold_next: valid %b mask %h state %h ovr %b required 1 02 02 0",
                      evt_valid, evt_mask, evt_state, evt_overrun);
    end
    @(negedge clk);
    chk++;
    if (evt_valid !== 1'b0) begin
      err++; $display("FAIL hold_idle: valid %b required 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_overrun();
    sw_raw = 8'h03;
    repeat (8) @(negedge clk);
    sw_raw = 8'h07;
    repeat (8) @(negedge clk);
    sw_raw = 8'h03;
    repeat (8) @(negedge clk);
    chk++;
    if ({evt_valid, evt_mask, evt_overrun} !== {1'b1, 8'h01, 1'b0}) begin
      err++; $display("FAIL ovr_pending: valid %b mask %h ovr %b required 1 01 0", evt_valid, evt_mask, evt_overrun);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    chk++;
    if ({evt_valid, evt_mask, evt_state, evt_overrun} !== {1'b1, 8'h04, 8'h03, 1'b1}) begin
      err++; $display("FAIL ovr_next: valid %b mask %h state %h ovr %b required 1 04 03 1",
                      evt_valid, evt_mask, evt_state, evt_overrun);
    end
    @(negedge clk);
    chk++;
    if (evt_valid !== 1'b0) begin
      err++; $display("FAIL ovr_idle: valid %b required 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    sw_raw = 8'h13;
    repeat (8) @(negedge clk);
    sw_raw = 8'h03;
    repeat (4) @(negedge clk);
    chk++;
    if (evt_valid !== 1'b1 || sw_stable !== 8'h13) begin
      err++; $display("FAIL areset_pre: valid %b stable %h required 1 13", evt_valid, sw_stable);
    end
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if (dut_vec !== '0) begin
      err++; $display("FAIL areset_async: got %h required 0", dut_vec);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk++;
      if (sw_stable !== 8'h00 || evt_valid !== 1'b0) begin
        err++; $display("FAIL areset_redebounce edge %0d: stable %h valid %b required 00 0", k, sw_stable, evt_valid);
      end
    end
    @(negedge clk);
    chk++;
    if ({sw_stable, sw_rise, evt_valid, evt_mask, evt_state} !== {8'h03, 8'h03, 1'b1, 8'h03, 8'h03}) begin
      err++; $display("FAIL areset_event: stable %h rise %h valid %b mask %h state %h required 03 03 1 03 03",
                      sw_stable, sw_rise, evt_valid, evt_mask, evt_state);
    end
  endtask

  task automatic test_all_bits();
    evt_ready = 1'b1;
    sw_raw = 8'h00;
    repeat (10) @(negedge clk);
    sw_raw = 8'hFF;
    repeat (5) @(negedge clk);
    chk++;
    if (sw_rise !== 8'h00 || evt_valid !== 1'b0) begin
      err++; $display("FAIL all_early: rise %h valid %b required 00 0", sw_rise, evt_valid);
    end
    @(negedge clk);
    chk++;
    if ({sw_stable, sw_rise, evt_valid, evt_mask, evt_state} !== {8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF}) begin
      err++; $display("FAIL all_edge: stable %h rise %h valid %b mask %h state %h required FF FF 1 FF FF",
                      sw_stable, sw_rise, evt_valid, evt_mask, evt_state);
    end
    @(negedge clk);
    chk++;
    if (sw_rise !== 8'h00 || evt_valid !== 1'b0) begin
      err++; $display("FAIL all_after: rise %h valid %b required 00 0", sw_rise, evt_valid);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      chk++;
      if (dut_vec !== mdl_vec) begin
        err++; $display("FAIL random cycle %0d: got %h required %h", k, dut_vec, mdl_vec);
      end
      if (hold == 0) begin
        if ($urandom_range(0, 2) == 0) sw_raw = 8'($urandom);
        else sw_raw = sw_raw ^ (8'h01 << $urandom_range(0, 7));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      evt_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_hold_queue();
    test_overrun();
    test_async_reset();
    test_all_bits();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
